mult_hilo_ctrl: RTL and testbench

Execute-stage sequencer between the ID/EX pipeline register and the shared sequential Multiplier.
- Accepts MULT requests and drives stable operands plus a start pulse to the Multiplier.
- Stalls the pipeline until the product is valid, then commits it to HI/LO registers.
- Serves MFHI/MFLO reads, stalling them while a multiply is in flight.

---
 rtl/mult_hilo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// Execute-stage sequencer for the shared sequential multiplier: launches MULT, stalls, commits HI/LO, serves MFHI/MFLO.
// Optional signed multiply support is enabled by defining MULT_SIGNED_EN.
module mult_hilo_ctrl #(
    parameter int unsigned MIN_WAIT = 2,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mult,
    input  logic        ex_signed,
    input  logic [15:0] ex_a,
    input  logic [15:0] ex_b,
    input  logic        ex_mfhi,
    input  logic        ex_mflo,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_start,
    input  logic [31:0] mul_r,
    input  logic        mul_valid
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]  hi;
    logic [DW-1:0]  lo;
    logic           accept;
    logic           capture;
    logic           expire;
    logic [DW-1:0]  a_in;
    logic [DW-1:0]  b_in;
    logic [PW-1:0]  prod;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; valid is trusted only after MIN_WAIT cycles to mask a stale one
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_mult && !done) begin
                    accept     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if ((cnt >= CNT_W'(MIN_WAIT)) && mul_valid) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign stall = busy | accept | (busy & (ex_mfhi | ex_mflo));

    // Register read port, HI wins when both reads are present
    always_comb begin
        rd_data = '0;
        if (ex_mfhi) begin
            rd_data = hi;
        end else if (ex_mflo) begin
            rd_data = lo;
        end
    end

`ifdef MULT_SIGNED_EN
    logic neg;
    logic neg_in;

    // Signed MULT feeds magnitudes to the unsigned multiplier and fixes the sign on capture
    always_comb begin
        a_in   = ex_a;
        b_in   = ex_b;
        neg_in = 1'b0;
        if (ex_signed) begin
            if (ex_a[DW-1]) begin
                a_in = ~ex_a + 16'd1;
            end
            if (ex_b[DW-1]) begin
                b_in = ~ex_b + 16'd1;
            end
            neg_in = ex_a[DW-1] ^ ex_b[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_in;
        end
    end

    assign prod = neg ? (~mul_r + 32'd1) : mul_r;
`else
    logic unused_signed;

    assign unused_signed = ex_signed;
    assign a_in          = ex_a;
    assign b_in          = ex_b;
    assign prod          = mul_r;
`endif

    // Operand latch, launch pulse, wait counter and HI/LO commit
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            mul_start <= accept;
            done      <= capture;
            if (accept) begin
                mul_a <= a_in;
                mul_b <= b_in;
            end
            if (state == ST_LAUNCH) begin
                cnt <= '0;
            end else if ((state == ST_WAIT) && !capture && !expire) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                hi <= prod[PW-1:DW];
                lo <= prod[DW-1:0];
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl with a behavioural multiplier and an arithmetic reference model.
module tb_mult_hilo_ctrl;

    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mult = 1'b0;
    logic        ex_signed = 1'b0;
    logic [15:0] ex_a = '0;
    logic [15:0] ex_b = '0;
    logic        ex_mfhi = 1'b0;
    logic        ex_mflo = 1'b0;
    logic [15:0] rd_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic [31:0] mul_r = '0;
    logic        mul_valid = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int n_start = 0;

    int   m_lat = 3;
    logic m_stuck = 1'b0;
    int   m_cnt = 0;
    logic m_run = 1'b0;

    logic [15:0] mhi = '0;
    logic [15:0] mlo = '0;
    logic        merr = 1'b0;

    mult_hilo_ctrl #(
        .MIN_WAIT(MIN_WAIT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_mult  (ex_mult),
        .ex_signed(ex_signed),
        .ex_a     (ex_a),
        .ex_b     (ex_b),
        .ex_mfhi  (ex_mfhi),
        .ex_mflo  (ex_mflo),
        .rd_data  (rd_data),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_start(mul_start),
        .mul_r    (mul_r),
        .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;

    // Sequential multiplier: previous valid lingers two cycles after start, new result m_lat cycles after start
    always @(posedge clk) begin
        if (mul_start) begin
            n_start <= n_start + 1;
            m_run   <= 1'b1;
            m_cnt   <= 1;
        end else if (m_run) begin
            if (!m_stuck && (m_cnt == m_lat - 1)) begin
                mul_valid <= 1'b1;
                mul_r     <= 32'(mul_a) * 32'(mul_b);
                m_run     <= 1'b0;
            end else begin
                if (m_cnt == 2) mul_valid <= 1'b0;
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic signed_mode(input logic sgn);
`ifdef MULT_SIGNED_EN
        return sgn;
`else
        return 1'b0 & sgn;
`endif
    endfunction

    function automatic longint as_num(input logic [15:0] v, input logic sgn);
        return signed_mode(sgn) ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        return 32'(as_num(a, sgn) * as_num(b, sgn));
    endfunction

    function automatic logic [15:0] ref_mag(input logic [15:0] v, input logic sgn);
        longint x;
        x = as_num(v, sgn);
        if (x < 0) x = -x;
        return 16'(x);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One MULT from acceptance (cycle 0) to its done cycle or timeout release
    task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                            input int lat, input logic stuck, input logic rd_lo);
        logic [31:0] prod;
        logic [15:0] ea;
        logic [15:0] eb;
        int          cap;
        int          last;
        logic        to;
        prod    = ref_prod(a, b, sgn);
        ea      = ref_mag(a, sgn);
        eb      = ref_mag(b, sgn);
        cap     = (2 + MIN_WAIT > 1 + lat) ? 2 + MIN_WAIT : 1 + lat;
        to      = stuck || (cap > 1 + TIMEOUT);
        last    = to ? 2 + TIMEOUT : cap + 1;
        m_lat   = lat;
        m_stuck = stuck;
        for (int cyc = 0; cyc <= last; cyc++) begin
            step();
            ex_mult   = !(to && cyc == last);
            ex_a      = a;
            ex_b      = b;
            ex_signed = sgn;
            ex_mfhi   = !rd_lo;
            ex_mflo   = rd_lo;
            #1;
            check("stall", 32'(stall), 32'(cyc < last));
            check("busy", 32'(busy), 32'(cyc > 0 && cyc < last));
            check("mul_start", 32'(mul_start), 32'(cyc == 1));
            check("done", 32'(done), 32'(!to && cyc == last));
            if (cyc == 1) begin
                check("mul_a", 32'(mul_a), 32'(ea));
                check("mul_b", 32'(mul_b), 32'(eb));
            end
        end
        if (to) merr = 1'b1;
        else begin
            mhi = prod[31:16];
            mlo = prod[15:0];
        end
        check("rd_at_end", 32'(rd_data), 32'(rd_lo ? mlo : mhi));
        check("err_at_end", 32'(err), 32'(merr));
    endtask

    // Idle-state register reads: no stall, HI priority, zero when nothing is read
    task automatic read_check();
        step();
        ex_mult = 1'b0; ex_mfhi = 1'b1; ex_mflo = 1'b1;
        #1;
        check("rd_both_hi", 32'(rd_data), 32'(mhi));
        check("idle_stall", 32'(stall), 32'(0));
        check("idle_err", 32'(err), 32'(merr));
        step();
        ex_mfhi = 1'b0; ex_mflo = 1'b1;
        #1;
        check("rd_lo", 32'(rd_data), 32'(mlo));
        check("idle_busy", 32'(busy), 32'(0));
        step();
        ex_mflo = 1'b0;
        #1;
        check("rd_none", 32'(rd_data), 32'(0));
        check("idle_done", 32'(done), 32'(0));
    endtask

    initial begin
        int s0;
        logic [15:0] ra, rb;

        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_start", 32'(mul_start), 32'(0));
        check("rst_mul_a", 32'(mul_a), 32'(0));
        check("rst_mul_b", 32'(mul_b), 32'(0));
        read_check();

        run_mult(16'd11, 16'd4, 1'b0, 3, 1'b0, 1'b0);
        read_check();
        run_mult(16'hFFFF, 16'hFFFF, 1'b0, 5, 1'b0, 1'b0);
        read_check();
        run_mult(16'hFFFD, 16'h0005, 1'b1, 4, 1'b0, 1'b0);
        read_check();
        run_mult(16'h8000, 16'h0002, 1'b1, 3, 1'b0, 1'b1);
        read_check();

        s0 = n_start;
        run_mult(16'd2, 16'd3, 1'b0, 3, 1'b0, 1'b1);
        run_mult(16'd7, 16'd7, 1'b0, 6, 1'b0, 1'b1);
        step();
        ex_mult = 1'b0;
        #1;
        check("b2b_starts", 32'(n_start - s0), 32'(2));
        read_check();

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 2) ra = 16'h8000;
            if (i == 3) rb = 16'h0000;
            run_mult(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(3, 10)),
                     1'b0, 1'($urandom_range(0, 1)));
            if (i % 3 == 0) read_check();
        end
        read_check();

        run_mult(16'd9, 16'd9, 1'b0, 3, 1'b1, 1'b0);
        read_check();

        // Reset two cycles into WAIT, then let the late valid arrive
        run_mult(16'h1234, 16'h0056, 1'b0, 5, 1'b0, 1'b0);
        read_check();
        m_lat = 8;
        m_stuck = 1'b0;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            step();
            ex_mult = 1'b1; ex_a = 16'd100; ex_b = 16'd200; ex_signed = 1'b0;
            ex_mfhi = 1'b0; ex_mflo = 1'b0;
            rst = (cyc == 4);
        end
        mhi = '0;
        mlo = '0;
        merr = 1'b0;
        step();
        rst = 1'b0; ex_mult = 1'b0; ex_mfhi = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_stall", 32'(stall), 32'(0));
        check("abort_hi", 32'(rd_data), 32'(0));
        check("abort_mul_a", 32'(mul_a), 32'(0));
        check("abort_err", 32'(err), 32'(0));
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            ex_mfhi = cyc[0]; ex_mflo = !cyc[0];
            #1;
            check("late_valid_rd", 32'(rd_data), 32'(0));
            check("late_valid_done", 32'(done), 32'(0));
            check("late_valid_busy", 32'(busy), 32'(0));
        end
        read_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
